mandelbrot_iter_pipe: RTL and testbench



---
 rtl/mandelbrot_iter_pipe.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_mandelbrot_iter_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_iter_pipe.sv
// Chained Mandelbrot iteration pipeline: STAGES units of z <= z^2 + c, 3 cycles each.
// Define MANDELBROT_SAT_EN to clamp the W-bit re/im arithmetic instead of wrapping.

module mandelbrot_iter_unit #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int CNT_W = 8,
  parameter int TAG_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic [W-1:0]     i_x,
  input  logic [W-1:0]     i_y,
  input  logic [W-1:0]     i_cx,
  input  logic [W-1:0]     i_cy,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_esc,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [W-1:0]     o_x,
  output logic [W-1:0]     o_y,
  output logic [W-1:0]     o_cx,
  output logic [W-1:0]     o_cy,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_esc,
  output logic [TAG_W-1:0] o_tag
);

`ifdef MANDELBROT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int MW = 2 * W + 1;
  // 4.0 in the 2*FRAC fractional scaling of the squared terms
  localparam logic [MW-1:0] MAG_LIM = MW'(1) << (2 * FRAC + 2);

  // Reduce a (W+1)-bit two's-complement value to W bits: clamp or wrap.
  function automatic logic [W-1:0] fit(input logic [W:0] v);
    logic ovf;
    ovf = v[W] ^ v[W-1];
    if (SAT && ovf) fit = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else            fit = v[W-1:0];
  endfunction

  // ---------------- Cycle A: squares and cross product ----------------
  logic             a_valid_q;
  logic [W-1:0]     a_x_q, a_y_q, a_cx_q, a_cy_q;
  logic [CNT_W-1:0] a_cnt_q;
  logic             a_esc_q;
  logic [TAG_W-1:0] a_tag_q;
  logic [2*W-1:0]   a_xx_q, a_yy_q, a_xy_q;

  logic [2*W-1:0]   x_ext, y_ext;
  logic [2*W-1:0]   a_xx_d, a_yy_d, a_xy_d;

  always_comb begin
    x_ext  = {{W{i_x[W-1]}}, i_x};
    y_ext  = {{W{i_y[W-1]}}, i_y};
    a_xx_d = x_ext * x_ext;
    a_yy_d = y_ext * y_ext;
    a_xy_d = x_ext * y_ext;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      a_valid_q <= 1'b0;
      a_x_q     <= '0;
      a_y_q     <= '0;
      a_cx_q    <= '0;
      a_cy_q    <= '0;
      a_cnt_q   <= '0;
      a_esc_q   <= 1'b0;
      a_tag_q   <= '0;
      a_xx_q    <= '0;
      a_yy_q    <= '0;
      a_xy_q    <= '0;
    end else begin
      a_valid_q <= i_valid;
      a_x_q     <= i_x;
      a_y_q     <= i_y;
      a_cx_q    <= i_cx;
      a_cy_q    <= i_cy;
      a_cnt_q   <= i_cnt;
      a_esc_q   <= i_esc;
      a_tag_q   <= i_tag;
      a_xx_q    <= a_xx_d;
      a_yy_q    <= a_yy_d;
      a_xy_q    <= a_xy_d;
    end
  end

  // ---------------- Cycle B: re, im and escape test ----------------
  logic             b_valid_q;
  logic [W-1:0]     b_x_q, b_y_q, b_cx_q, b_cy_q;
  logic [CNT_W-1:0] b_cnt_q;
  logic             b_esc_q;
  logic [TAG_W-1:0] b_tag_q;
  logic [W-1:0]     b_re_q, b_im_q;
  logic             b_mag_q;

  logic [W-1:0]     xx_s, yy_s, xy_s;
  logic [MW-1:0]    mag_sum;
  logic [W-1:0]     b_re_d, b_im_d;
  logic             b_mag_d;
  logic             unused_xy;

  assign unused_xy = ^{a_xy_q[2*W-1:FRAC+W], a_xy_q[FRAC-1:0]};

  always_comb begin
    xx_s    = a_xx_q[FRAC+W-1:FRAC];
    yy_s    = a_yy_q[FRAC+W-1:FRAC];
    xy_s    = a_xy_q[FRAC+W-1:FRAC];
    b_re_d  = fit({xx_s[W-1], xx_s} - {yy_s[W-1], yy_s});
    b_im_d  = fit({xy_s, 1'b0});
    // Squares are non-negative, so zero extension keeps the full magnitude
    mag_sum = {1'b0, a_xx_q} + {1'b0, a_yy_q};
    b_mag_d = mag_sum > MAG_LIM;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      b_valid_q <= 1'b0;
      b_x_q     <= '0;
      b_y_q     <= '0;
      b_cx_q    <= '0;
      b_cy_q    <= '0;
      b_cnt_q   <= '0;
      b_esc_q   <= 1'b0;
      b_tag_q   <= '0;
      b_re_q    <= '0;
      b_im_q    <= '0;
      b_mag_q   <= 1'b0;
    end else begin
      b_valid_q <= a_valid_q;
      b_x_q     <= a_x_q;
      b_y_q     <= a_y_q;
      b_cx_q    <= a_cx_q;
      b_cy_q    <= a_cy_q;
      b_cnt_q   <= a_cnt_q;
      b_esc_q   <= a_esc_q;
      b_tag_q   <= a_tag_q;
      b_re_q    <= b_re_d;
      b_im_q    <= b_im_d;
      b_mag_q   <= b_mag_d;
    end
  end

  // ---------------- Cycle C: update or freeze ----------------
  logic             c_valid_q;
  logic [W-1:0]     c_x_q, c_y_q, c_cx_q, c_cy_q;
  logic [CNT_W-1:0] c_cnt_q;
  logic             c_esc_q;
  logic [TAG_W-1:0] c_tag_q;

  logic [W-1:0]     c_x_d, c_y_d;
  logic [CNT_W-1:0] c_cnt_d;
  logic             c_esc_d;

  always_comb begin
    c_x_d   = b_x_q;
    c_y_d   = b_y_q;
    c_cnt_d = b_cnt_q;
    c_esc_d = b_esc_q;
    if (b_valid_q && !b_esc_q) begin
      if (b_mag_q) begin
        c_esc_d = 1'b1;
      end else begin
        c_x_d   = fit({b_re_q[W-1], b_re_q} + {b_cx_q[W-1], b_cx_q});
        c_y_d   = fit({b_im_q[W-1], b_im_q} + {b_cy_q[W-1], b_cy_q});
        c_cnt_d = (&b_cnt_q) ? b_cnt_q : b_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      c_valid_q <= 1'b0;
      c_x_q     <= '0;
      c_y_q     <= '0;
      c_cx_q    <= '0;
      c_cy_q    <= '0;
      c_cnt_q   <= '0;
      c_esc_q   <= 1'b0;
      c_tag_q   <= '0;
    end else begin
      c_valid_q <= b_valid_q;
      c_x_q     <= c_x_d;
      c_y_q     <= c_y_d;
      c_cx_q    <= b_cx_q;
      c_cy_q    <= b_cy_q;
      c_cnt_q   <= c_cnt_d;
      c_esc_q   <= c_esc_d;
      c_tag_q   <= b_tag_q;
    end
  end

  assign o_valid = c_valid_q;
  assign o_x     = c_x_q;
  assign o_y     = c_y_q;
  assign o_cx    = c_cx_q;
  assign o_cy    = c_cy_q;
  assign o_cnt   = c_cnt_q;
  assign o_esc   = c_esc_q;
  assign o_tag   = c_tag_q;

endmodule

module mandelbrot_iter_pipe #(
  parameter int W      = 16,
  parameter int FRAC   = 12,
  parameter int CNT_W  = 8,
  parameter int TAG_W  = 12,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic [W-1:0]     i_x,
  input  logic [W-1:0]     i_y,
  input  logic [W-1:0]     i_cx,
  input  logic [W-1:0]     i_cy,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_esc,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [W-1:0]     o_x,
  output logic [W-1:0]     o_y,
  output logic [W-1:0]     o_cx,
  output logic [W-1:0]     o_cy,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_esc,
  output logic [TAG_W-1:0] o_tag
);

  // Element 0 is the block input, element STAGES the block output
  logic             ch_valid [STAGES+1];
  logic [W-1:0]     ch_x     [STAGES+1];
  logic [W-1:0]     ch_y     [STAGES+1];
  logic [W-1:0]     ch_cx    [STAGES+1];
  logic [W-1:0]     ch_cy    [STAGES+1];
  logic [CNT_W-1:0] ch_cnt   [STAGES+1];
  logic             ch_esc   [STAGES+1];
  logic [TAG_W-1:0] ch_tag   [STAGES+1];

  assign ch_valid[0] = i_valid;
  assign ch_x[0]     = i_x;
  assign ch_y[0]     = i_y;
  assign ch_cx[0]    = i_cx;
  assign ch_cy[0]    = i_cy;
  assign ch_cnt[0]   = i_cnt;
  assign ch_esc[0]   = i_esc;
  assign ch_tag[0]   = i_tag;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_unit
    mandelbrot_iter_unit #(
      .W    (W),
      .FRAC (FRAC),
      .CNT_W(CNT_W),
      .TAG_W(TAG_W)
    ) u_unit (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_valid(ch_valid[gi]),
      .i_x    (ch_x[gi]),
      .i_y    (ch_y[gi]),
      .i_cx   (ch_cx[gi]),
      .i_cy   (ch_cy[gi]),
      .i_cnt  (ch_cnt[gi]),
      .i_esc  (ch_esc[gi]),
      .i_tag  (ch_tag[gi]),
      .o_valid(ch_valid[gi+1]),
      .o_x    (ch_x[gi+1]),
      .o_y    (ch_y[gi+1]),
      .o_cx   (ch_cx[gi+1]),
      .o_cy   (ch_cy[gi+1]),
      .o_cnt  (ch_cnt[gi+1]),
      .o_esc  (ch_esc[gi+1]),
      .o_tag  (ch_tag[gi+1])
    );
  end

  assign o_valid = ch_valid[STAGES];
  assign o_x     = ch_x[STAGES];
  assign o_y     = ch_y[STAGES];
  assign o_cx    = ch_cx[STAGES];
  assign o_cy    = ch_cy[STAGES];
  assign o_cnt   = ch_cnt[STAGES];
  assign o_esc   = ch_esc[STAGES];
  assign o_tag   = ch_tag[STAGES];

endmodule

// File: tb/tb_mandelbrot_iter_pipe.sv
// Directed bench for mandelbrot_iter_pipe: a 4-stage instance plus a 1-stage instance
// for the overflow vector; expectation follows MANDELBROT_SAT_EN.

module tb_mandelbrot_iter_pipe;
  localparam int W = 16, FRAC = 12, CNT_W = 8, TAG_W = 12, ST = 4;

`ifdef MANDELBROT_SAT_EN
  localparam logic [W-1:0] EXP_OVF_X = 16'h7FFF;
`else
  localparam logic [W-1:0] EXP_OVF_X = 16'hB040;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn, vld, esc;
  logic [W-1:0]     x, y, cx, cy;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag;

  logic             o_valid, o_esc, p_valid, p_esc;
  logic [W-1:0]     o_x, o_y, o_cx, o_cy, p_x, p_y, p_cx, p_cy;
  logic [CNT_W-1:0] o_cnt, p_cnt;
  logic [TAG_W-1:0] o_tag, p_tag;

  int total = 0;
  int bad   = 0;

  // Expected-output delay line for the streaming test (index 11 = visible now)
  logic             pv_v [12];
  logic [TAG_W-1:0] pv_t [12];
  logic [CNT_W-1:0] pv_c [12];

  mandelbrot_iter_pipe #(.W(W), .FRAC(FRAC), .CNT_W(CNT_W), .TAG_W(TAG_W), .STAGES(ST)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(vld), .i_x(x), .i_y(y), .i_cx(cx), .i_cy(cy),
    .i_cnt(cnt), .i_esc(esc), .i_tag(tag),
    .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_cx(o_cx), .o_cy(o_cy),
    .o_cnt(o_cnt), .o_esc(o_esc), .o_tag(o_tag)
  );

  mandelbrot_iter_pipe #(.W(W), .FRAC(FRAC), .CNT_W(CNT_W), .TAG_W(TAG_W), .STAGES(1)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(vld), .i_x(x), .i_y(y), .i_cx(cx), .i_cy(cy),
    .i_cnt(cnt), .i_esc(esc), .i_tag(tag),
    .o_valid(p_valid), .o_x(p_x), .o_y(p_y), .o_cx(p_cx), .o_cy(p_cy),
    .o_cnt(p_cnt), .o_esc(p_esc), .o_tag(p_tag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("check %s observed=%h expected=%h", name, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] dx, input logic [W-1:0] dy,
                       input logic [W-1:0] dcx, input logic [W-1:0] dcy,
                       input logic [CNT_W-1:0] dcnt, input logic desc,
                       input logic [TAG_W-1:0] dtag);
    vld = 1'b1; x = dx; y = dy; cx = dcx; cy = dcy; cnt = dcnt; esc = desc; tag = dtag;
  endtask

  // One sample through the 4-stage pipe; returns positioned on its output cycle
  task automatic send4(input string name);
    tick();
    vld = 1'b0;
    repeat (3 * ST - 2) tick();
    chk({name, "_early_valid"}, o_valid, 0);
    tick();
    chk({name, "_valid"}, o_valid, 1);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 12; k++) begin
      pv_v[k] = 1'b0; pv_t[k] = '0; pv_c[k] = '0;
    end
  endtask

  task automatic model_step(input logic mv, input logic [TAG_W-1:0] mt, input logic [CNT_W-1:0] mc);
    for (int k = 11; k > 0; k--) begin
      pv_v[k] = pv_v[k-1]; pv_t[k] = pv_t[k-1]; pv_c[k] = pv_c[k-1];
    end
    pv_v[0] = mv; pv_t[0] = mt; pv_c[0] = mc;
  endtask

  task automatic stream_cmp();
    chk("s_valid", o_valid, pv_v[11]);
    chk("s_tag",   o_tag,   pv_t[11]);
    chk("s_cnt",   o_cnt,   pv_c[11]);
  endtask

  initial begin
    rstn = 1'b0;
    vld = 1'b0; x = '0; y = '0; cx = '0; cy = '0; cnt = '0; esc = 1'b0; tag = '0;
    repeat (3) tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_esc",   o_esc,   0);
    chk("rst_x",     o_x,     0);
    chk("rst_cnt",   o_cnt,   0);
    chk("rst_tag",   o_tag,   0);
    rstn = 1'b1;

    // 1: origin stays at origin, four iterations counted
    drive(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd0, 1'b0, 12'd1);
    send4("t1");
    chk("t1_x", o_x, 16'h0000);
    chk("t1_y", o_y, 16'h0000);
    chk("t1_cnt", o_cnt, 8'd4);
    chk("t1_esc", o_esc, 0);
    chk("t1_tag", o_tag, 12'd1);

    // 2: |z|^2 = 6.25 escapes in the first unit and freezes
    drive(16'h2800, 16'h0000, 16'h0000, 16'h0000, 8'd5, 1'b0, 12'd2);
    send4("t2");
    chk("t2_esc", o_esc, 1);
    chk("t2_x", o_x, 16'h2800);
    chk("t2_y", o_y, 16'h0000);
    chk("t2_cnt", o_cnt, 8'd5);

    // 2b: already-escaped input passes untouched
    drive(16'h0100, 16'h0000, 16'h0300, 16'h0000, 8'd7, 1'b1, 12'd3);
    send4("t2b");
    chk("t2b_esc", o_esc, 1);
    chk("t2b_x", o_x, 16'h0100);
    chk("t2b_cnt", o_cnt, 8'd7);
    chk("t2b_cx", o_cx, 16'h0300);

    // 3: c = -2 lands on |z|^2 = 4 exactly, which is not an escape
    drive(16'h0000, 16'h0000, 16'hE000, 16'h0000, 8'd0, 1'b0, 12'd4);
    send4("t3");
    chk("t3_x", o_x, 16'h2000);
    chk("t3_cnt", o_cnt, 8'd4);
    chk("t3_esc", o_esc, 0);
    chk("t3_cx", o_cx, 16'hE000);

    // 4: counter saturates at 0xFF
    drive(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'hFE, 1'b0, 12'd5);
    send4("t4");
    chk("t4_cnt", o_cnt, 8'hFF);
    chk("t4_esc", o_esc, 0);

    // 5: 1.875^2 + 7.5 overflows the W-bit result (single-stage instance)
    drive(16'h1E00, 16'h0000, 16'h7800, 16'h0000, 8'd0, 1'b0, 12'd6);
    tick();
    vld = 1'b0;
    tick();
    chk("t5_early_valid", p_valid, 0);
    tick();
    chk("t5_valid", p_valid, 1);
    chk("t5_x", p_x, EXP_OVF_X);
    chk("t5_esc", p_esc, 0);
    chk("t5_cnt", p_cnt, 8'd1);
    chk("t5_tag", p_tag, 12'd6);

    // Flush with all-zero samples so the stream model starts from a known pipe
    vld = 1'b0; x = '0; y = '0; cx = '0; cy = '0; cnt = '0; esc = 1'b0; tag = '0;
    repeat (3 * ST) tick();
    model_clear();

    // 6: 20-sample stream, valid pattern 1,0,1,1, reset pulse mid-stream
    for (int i = 0; i < 20; i++) begin
      if (i == 14) begin
        rstn = 1'b0;
        #1;
        chk("rst_mid_valid", o_valid, 0);
        chk("rst_mid_tag",   o_tag,   0);
        chk("rst_mid_cnt",   o_cnt,   0);
        model_clear();
        tick();
        model_step(1'b0, '0, '0);
        stream_cmp();
        rstn = 1'b1;
      end
      drive(16'h0000, 16'h0000, 16'h0000, 16'h0000, CNT_W'(i), 1'b0, TAG_W'(i));
      vld = ((i % 4) != 1);
      tick();
      model_step(vld, TAG_W'(i), vld ? CNT_W'(i + 4) : CNT_W'(i));
      stream_cmp();
    end
    vld = 1'b0; cnt = '0; tag = '0;
    for (int j = 0; j < 3 * ST; j++) begin
      tick();
      model_step(1'b0, '0, '0);
      stream_cmp();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
